// File: rtl/systolic_matmul_top_if.sv
// ----------------------------------------------------------------------------
// systolic_matmul_top_if
// Host-side bundle for the systolic matrix-multiply accelerator.
//   start        : one-cycle pulse that launches an armed MATMUL
//   w_valid/wdata: per-column weight strobes, element j in slice j
//   if_valid/if_data : per-column activation strobes, element k in slice k
//   instr_valid/instr: instruction strobe and opcode
//   ready        : unit is idle
//   read_out/o_data  : per-column result strobe and result value
// master = host/loader side, slave = accelerator side.
// ----------------------------------------------------------------------------
interface systolic_matmul_top_if #(
   parameter int SYS_COLS   = 4,
   parameter int W_BITWIDTH = 8,
   parameter int P_BITWIDTH = 32,
   parameter int INSTR_SIZE = 2
);
   logic                           start;
   logic [SYS_COLS-1:0]            w_valid;
   logic [SYS_COLS*W_BITWIDTH-1:0] wdata;
   logic [SYS_COLS-1:0]            if_valid;
   logic [SYS_COLS*W_BITWIDTH-1:0] if_data;
   logic                           instr_valid;
   logic [INSTR_SIZE-1:0]          instr;
   logic                           ready;
   logic [SYS_COLS-1:0]            read_out;
   logic [SYS_COLS*P_BITWIDTH-1:0] o_data;

   modport master (
      output start, w_valid, wdata, if_valid, if_data, instr_valid, instr,
      input  ready, read_out, o_data
   );

   modport slave (
      input  start, w_valid, wdata, if_valid, if_data, instr_valid, instr,
      output ready, read_out, o_data
   );
endinterface

// File: rtl/systolic_matmul_top.sv
// ----------------------------------------------------------------------------
// systolic_matmul_top
// Weight-stationary systolic array computing C = A x W.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of systolic_matmul_top_if (loads, instruction, start,
//          ready, per-column result stream)
// Weights sit in PE(r,j); activations enter column 0 skewed by row and move
// right one PE per cycle; partial sums move down one PE per cycle. The last
// PE row writes straight into the per-column output register so C[i][j]
// lands on o_data[j] at edge i+SYS_ROWS+j after the run starts.
// Requires SYS_ROWS >= 2 and SYS_COLS == SYS_ROWS.
// ----------------------------------------------------------------------------
module systolic_matmul_top #(
   parameter int SYS_ROWS   = 4,
   parameter int SYS_COLS   = 4,
   parameter int A_ROWS     = 4,
   parameter int W_BITWIDTH = 8,
   parameter int P_BITWIDTH = 32,
   parameter int INSTR_SIZE = 2
) (
   input logic                  clk,
   input logic                  rst,
   systolic_matmul_top_if.slave bus
);
   localparam int AW = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
   localparam int CW = $clog2(A_ROWS + SYS_ROWS + SYS_COLS);
   // Run counter value on the edge after the final output of the last column.
   localparam logic [CW-1:0]         LAST_CNT  = CW'(A_ROWS + SYS_ROWS + SYS_COLS - 1);
   localparam logic [AW-1:0]         WPTR_LAST = AW'(A_ROWS - 1);
   localparam logic [INSTR_SIZE-1:0] OP_MATMUL = INSTR_SIZE'(3);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic                  w_ready;
   logic [CW-1:0]         r_cnt;
   logic [INSTR_SIZE-1:0] r_armed;
   logic [AW-1:0]         r_wptr;

   logic [W_BITWIDTH-1:0] r_w     [SYS_ROWS][SYS_COLS];
   logic [W_BITWIDTH-1:0] r_abuf  [SYS_ROWS][A_ROWS];
   logic [W_BITWIDTH-1:0] r_act   [SYS_ROWS][SYS_COLS];
   logic [P_BITWIDTH-1:0] r_psum  [SYS_ROWS-1][SYS_COLS];
   logic [P_BITWIDTH-1:0] r_odata [SYS_COLS];
   logic [SYS_COLS-1:0]   r_read_out;

   logic                           w_idle;
   logic                           w_run;
   logic                           w_go;
   logic                           w_done;
   logic [W_BITWIDTH-1:0]          w_inject [SYS_ROWS];
   logic [P_BITWIDTH-1:0]          w_psum   [SYS_ROWS][SYS_COLS];
   logic [SYS_COLS-1:0]            w_out_valid;
   logic [SYS_COLS*P_BITWIDTH-1:0] w_odata_flat;

   assign w_idle = (r_state == S_IDLE);
   assign w_run  = (r_state == S_RUN);
   assign w_go   = w_idle && bus.start && (r_armed == OP_MATMUL);
   assign w_done = w_run && (r_cnt == LAST_CNT);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (w_go) w_state_next = S_RUN;
         end
         S_RUN: begin
            if (w_done) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // ---------------- Loading, instruction, run counter ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_armed <= '0;
         r_wptr  <= '0;
         for (int r = 0; r < SYS_ROWS; r++) begin
            for (int j = 0; j < SYS_COLS; j++) r_w[r][j] <= '0;
            for (int i = 0; i < A_ROWS; i++)   r_abuf[r][i] <= '0;
         end
      end else begin
         // r_cnt equals the edge index relative to cycle 0 while running.
         r_cnt <= w_run ? r_cnt + CW'(1) : '0;

         if (w_go)                            r_armed <= '0;
         else if (w_idle && bus.instr_valid)  r_armed <= bus.instr;

         if (w_done) begin
            r_wptr <= '0;
         end else if (w_idle && (|bus.if_valid)) begin
            r_wptr <= (r_wptr == WPTR_LAST) ? '0 : r_wptr + AW'(1);
            for (int k = 0; k < SYS_ROWS; k++) begin
               if (bus.if_valid[k]) r_abuf[k][r_wptr] <= bus.if_data[k*W_BITWIDTH +: W_BITWIDTH];
            end
         end

         // Each weight column is a shift chain fed at row 0.
         if (w_idle) begin
            for (int j = 0; j < SYS_COLS; j++) begin
               if (bus.w_valid[j]) begin
                  r_w[0][j] <= bus.wdata[j*W_BITWIDTH +: W_BITWIDTH];
                  for (int r = 1; r < SYS_ROWS; r++) r_w[r][j] <= r_w[r-1][j];
               end
            end
         end
      end
   end

   // ---------------- Skewed injection and output window ----------------
   // Row k of the array receives A[t-k][k] at edge t; zero outside the window
   // so idle/draining cycles carry no data.
   always_comb begin
      for (int k = 0; k < SYS_ROWS; k++) begin
         w_inject[k] = '0;
         if (w_run && (int'(r_cnt) >= k) && (int'(r_cnt) < k + A_ROWS))
            w_inject[k] = r_abuf[k][AW'(int'(r_cnt) - k)];
      end
      w_out_valid = '0;
      for (int j = 0; j < SYS_COLS; j++) begin
         if (w_run && (int'(r_cnt) >= SYS_ROWS + j) && (int'(r_cnt) < SYS_ROWS + j + A_ROWS))
            w_out_valid[j] = 1'b1;
      end
   end

   // ---------------- PE arithmetic ----------------
   genvar gi, gj;
   generate
      for (gi = 0; gi < SYS_ROWS; gi++) begin : g_row
         for (gj = 0; gj < SYS_COLS; gj++) begin : g_col
            logic [P_BITWIDTH-1:0] w_prod;
            assign w_prod = P_BITWIDTH'(r_act[gi][gj]) * P_BITWIDTH'(r_w[gi][gj]);
            if (gi == 0) begin : g_top
               assign w_psum[gi][gj] = w_prod;
            end else begin : g_mid
               assign w_psum[gi][gj] = r_psum[gi-1][gj] + w_prod;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_read_out <= '0;
         for (int j = 0; j < SYS_COLS; j++) r_odata[j] <= '0;
         for (int k = 0; k < SYS_ROWS; k++)
            for (int j = 0; j < SYS_COLS; j++) r_act[k][j] <= '0;
         for (int k = 0; k < SYS_ROWS - 1; k++)
            for (int j = 0; j < SYS_COLS; j++) r_psum[k][j] <= '0;
      end else begin
         for (int k = 0; k < SYS_ROWS; k++) begin
            r_act[k][0] <= w_inject[k];
            for (int j = 1; j < SYS_COLS; j++) r_act[k][j] <= r_act[k][j-1];
         end
         for (int k = 0; k < SYS_ROWS - 1; k++)
            for (int j = 0; j < SYS_COLS; j++) r_psum[k][j] <= w_psum[k][j];
         // Bottom PE row writes the output register only inside the window,
         // so o_data holds its last result between bursts.
         r_read_out <= w_out_valid;
         for (int j = 0; j < SYS_COLS; j++)
            if (w_out_valid[j]) r_odata[j] <= w_psum[SYS_ROWS-1][j];
      end
   end

   always_comb begin
      w_odata_flat = '0;
      for (int j = 0; j < SYS_COLS; j++) w_odata_flat[j*P_BITWIDTH +: P_BITWIDTH] = r_odata[j];
   end

   assign bus.ready    = w_ready;
   assign bus.read_out = r_read_out;
   assign bus.o_data   = w_odata_flat;
endmodule

// File: tb/tb_systolic_matmul_top.sv
// ----------------------------------------------------------------------------
// tb_systolic_matmul_top
// Directed and random runs of systolic_matmul_top. Expected results come from
// a golden A x W model and are queued per column before start; a monitor pops
// them as read_out pulses appear.
// ----------------------------------------------------------------------------
module tb_systolic_matmul_top;
   localparam int R  = 4;
   localparam int C  = 4;
   localparam int A  = 4;
   localparam int WB = 8;
   localparam int PB = 32;
   localparam int IS = 2;
   // Edge (relative to cycle 0) on which ready returns high.
   localparam int RUN_LEN = A + R + C - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   systolic_matmul_top_if #(.SYS_COLS(C), .W_BITWIDTH(WB), .P_BITWIDTH(PB), .INSTR_SIZE(IS)) bus ();

   systolic_matmul_top #(
      .SYS_ROWS(R), .SYS_COLS(C), .A_ROWS(A),
      .W_BITWIDTH(WB), .P_BITWIDTH(PB), .INSTR_SIZE(IS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [PB-1:0] exp_q  [C][$];
   logic [PB-1:0] last_c [C];
   int            pulse_cnt [C];
   int unsigned   ma [A][R];
   int unsigned   mw [R][C];

   task automatic check(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every pulse must match the head of its column queue.
   always @(negedge clk) begin
      if (rst) begin
         for (int j = 0; j < C; j++) begin
            if (bus.read_out[j]) begin
               pulse_cnt[j]++;
               check($sformatf("col%0d_expect_pending", j), PB'(exp_q[j].size() > 0), 1);
               if (exp_q[j].size() > 0)
                  check($sformatf("col%0d_data", j), bus.o_data[j*PB +: PB], exp_q[j].pop_front());
            end
         end
      end
   end

   task automatic idle_inputs();
      bus.start       = 1'b0;
      bus.w_valid     = '0;
      bus.wdata       = '0;
      bus.if_valid    = '0;
      bus.if_data     = '0;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
   endtask

   task automatic randomize_mats(input int unsigned lo, input int unsigned hi);
      for (int i = 0; i < A; i++)
         for (int k = 0; k < R; k++) ma[i][k] = $urandom_range(hi, lo);
      for (int k = 0; k < R; k++)
         for (int j = 0; j < C; j++) mw[k][j] = $urandom_range(hi, lo);
   endtask

   // Weight rows go bottom-up so PE(r,j) ends up with W[r][j].
   task automatic load_all();
      for (int r = R - 1; r >= 0; r--) begin
         @(negedge clk);
         bus.w_valid = '1;
         for (int j = 0; j < C; j++) bus.wdata[j*WB +: WB] = WB'(mw[r][j]);
      end
      for (int i = 0; i < A; i++) begin
         @(negedge clk);
         bus.w_valid  = '0;
         bus.if_valid = '1;
         for (int k = 0; k < R; k++) bus.if_data[k*WB +: WB] = WB'(ma[i][k]);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic arm(input logic [IS-1:0] op);
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr       = op;
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic push_golden();
      logic [PB-1:0] sum;
      for (int i = 0; i < A; i++) begin
         for (int j = 0; j < C; j++) begin
            sum = '0;
            for (int k = 0; k < R; k++) sum = sum + PB'(ma[i][k] * mw[k][j]);
            exp_q[j].push_back(sum);
            if (i == A - 1) last_c[j] = sum;
         end
      end
   endtask

   task automatic pulse_start();
      for (int j = 0; j < C; j++) pulse_cnt[j] = 0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic run_check(input string tag);
      logic [C-1:0] exp_ro;
      push_golden();
      pulse_start();
      check({tag, "_ready_start"}, PB'(bus.ready), 0);
      for (int t = 0; t <= RUN_LEN; t++) begin
         @(negedge clk);
         exp_ro = '0;
         for (int j = 0; j < C; j++)
            if ((t - R - j >= 0) && (t - R - j < A)) exp_ro[j] = 1'b1;
         check($sformatf("%s_read_out_t%0d", tag, t), PB'(bus.read_out), PB'(exp_ro));
         check($sformatf("%s_ready_t%0d", tag, t), PB'(bus.ready), PB'(t == RUN_LEN));
      end
      for (int j = 0; j < C; j++) begin
         check($sformatf("%s_pulses_c%0d", tag, j), PB'(pulse_cnt[j]), PB'(A));
         check($sformatf("%s_leftover_c%0d", tag, j), PB'(exp_q[j].size()), 0);
         check($sformatf("%s_hold_c%0d", tag, j), bus.o_data[j*PB +: PB], last_c[j]);
      end
   endtask

   task automatic expect_ignored(input string tag);
      pulse_start();
      for (int t = 0; t <= RUN_LEN + 1; t++) begin
         @(negedge clk);
         check($sformatf("%s_ready_t%0d", tag, t), PB'(bus.ready), 1);
         check($sformatf("%s_read_out_t%0d", tag, t), PB'(bus.read_out), 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", PB'(bus.ready), 1);
      check("rst_read_out", PB'(bus.read_out), 0);
      for (int j = 0; j < C; j++) check($sformatf("rst_o_data_c%0d", j), bus.o_data[j*PB +: PB], 0);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_ready", PB'(bus.ready), 1);

      // Identity weights: outputs reproduce A column by column.
      for (int i = 0; i < A; i++)
         for (int k = 0; k < R; k++) ma[i][k] = i * 4 + k + 1;
      for (int k = 0; k < R; k++)
         for (int j = 0; j < C; j++) mw[k][j] = (k == j) ? 1 : 0;
      load_all();
      arm(2'b11);
      run_check("ident");
      $display("run ident done: %0d assertions so far", n_assert);

      // Armed opcode is consumed by the run.
      expect_ignored("no_rearm");
      $display("run no_rearm done");

      randomize_mats(255, 255);
      load_all();
      arm(2'b11);
      run_check("max");
      $display("run max done: col0 last=%0d", last_c[0]);

      expect_ignored("no_instr");
      $display("run no_instr done");
      arm(2'b01);
      expect_ignored("nop_instr");
      $display("run nop_instr done");
      arm(2'b11);
      arm(2'b10);
      expect_ignored("overwritten_instr");
      $display("run overwritten_instr done");

      randomize_mats(0, 255);
      load_all();
      arm(2'b11);
      run_check("b2b_1");
      $display("run b2b_1 done");
      randomize_mats(0, 255);
      load_all();
      arm(2'b11);
      run_check("b2b_2");
      $display("run b2b_2 done");

      // Abort a run with reset part way through the output stream.
      randomize_mats(1, 255);
      load_all();
      arm(2'b11);
      push_golden();
      pulse_start();
      repeat (6) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("abort_ready", PB'(bus.ready), 1);
      check("abort_read_out", PB'(bus.read_out), 0);
      for (int j = 0; j < C; j++) check($sformatf("abort_o_data_c%0d", j), bus.o_data[j*PB +: PB], 0);
      for (int j = 0; j < C; j++) exp_q[j].delete();
      @(negedge clk);
      rst = 1'b1;
      for (int t = 0; t < RUN_LEN; t++) begin
         @(negedge clk);
         check($sformatf("abort_quiet_t%0d", t), PB'(bus.read_out), 0);
      end
      $display("run abort done");
      load_all();
      arm(2'b11);
      run_check("after_rst");
      $display("run after_rst done");

      for (int n = 0; n < 20; n++) begin
         randomize_mats(0, 255);
         load_all();
         arm(2'b11);
         run_check($sformatf("rnd%0d", n));
         $display("run rnd%0d done: %0d assertions so far", n, n_assert);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
